ecc_mem_scrubber: RTL and testbench

Background SEC-DED scrubbing engine for the core's ECC-protected data memory. It walks every memory word during idle bus slots, decodes each 39-bit codeword, and writes back corrected codewords for single-bit errors. Double-bit errors are counted and reported without any write. It sits beside the data-memory read path, behind the core-side Hamming decode, and shares the memory port through an external arbiter that grants it only when the core is not accessing memory.

---
 rtl/ecc_pkg.sv | 30 +++
 rtl/secded39_dec.sv | 41 ++++
 rtl/ecc_mem_scrubber.sv | 169 ++++++++++++++++
 tb/tb_ecc_mem_scrubber.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared constants and types for the SEC-DED (39,32) memory protection logic.
package ecc_pkg;

  localparam int CW_W   = 39;
  localparam int DATA_W = 32;
  // Number of Hamming check bits; bit 0 (overall parity) comes on top.
  localparam int SYN_W  = CW_W - DATA_W - 1;

  // Check bits sit at Hamming positions 1, 2, 4, 8, 16, 32.
  localparam logic [CW_W-1:0] CHK_MASK = 39'h1_0001_0116;

  // Highest valid Hamming position; larger syndromes cannot name a bit.
  localparam logic [SYN_W-1:0] MAX_POS = SYN_W'(CW_W - 1);

  typedef enum logic [1:0] {
    CLEAN,
    CORR,
    UNCORR
  } syn_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CHECK,
    ST_WRITE,
    ST_NEXT
  } scrub_state_e;

endpackage

// File: rtl/secded39_dec.sv
// Combinational SEC-DED decoder for the 39-bit codeword. Bit 0 is overall
// parity, bits 1..38 are Hamming positions. Shared with the core read path.
module secded39_dec
  import ecc_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output syn_class_e      syn_class,
  output logic [CW_W-1:0] corr_cw
);

  logic [SYN_W-1:0] syndrome;
  logic             parity;

  // Syndrome is the XOR of the position indices of every set bit in 1..38.
  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (cw[i]) syndrome = syndrome ^ SYN_W'(i);
    end
  end

  assign parity = ^cw;

  // Classify; with odd overall parity the syndrome names the faulty bit,
  // and syndrome 0 then points at the parity bit itself.
  always_comb begin
    syn_class = CLEAN;
    corr_cw   = cw;
    if (parity) begin
      if (syndrome <= MAX_POS) begin
        syn_class = CORR;
        corr_cw   = cw ^ (CW_W'(1) << syndrome);
      end else begin
        syn_class = UNCORR;
      end
    end else if (syndrome != '0) begin
      syn_class = UNCORR;
    end
  end

endmodule

// File: rtl/ecc_mem_scrubber.sv
// Background scrubber: walks the ECC data memory in idle bus slots, writes
// back corrected codewords for single-bit errors, counts and reports all
// detected errors.
//
// Memory handshake: mem_req is held with mem_addr/mem_we/mem_wdata stable
// until the arbiter returns mem_gnt in the same cycle; the access happens in
// the cycle where mem_req and mem_gnt are both 1. Read data arrives on
// mem_rdata in the following cycle.
module ecc_mem_scrubber
  import ecc_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [38:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [38:0]       mem_rdata,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  output logic              busy,
  output logic              err_valid,
  output logic              err_uncorr,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       corr_cnt,
  output logic [15:0]       uncorr_cnt,
  output logic              pass_done
);

  localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  ivl_q;
  logic [CW_W-1:0]   rdata_q;
  logic [CW_W-1:0]   wdata_q;
  logic              abort_q;
  logic              err_valid_q;
  logic              err_uncorr_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [15:0]       corr_q;
  logic [15:0]       uncorr_q;
  logic              pass_done_q;

  syn_class_e        syn_class;
  logic [CW_W-1:0]   corr_cw;
  logic              race;
  logic              in_race_window;

  secded39_dec u_dec (
    .cw        (rdata_q),
    .syn_class (syn_class),
    .corr_cw   (corr_cw)
  );

  // A core write to the word being scrubbed makes our copy stale; the window
  // opens with the read grant and closes with the write grant.
  assign in_race_window = (state_q == ST_READ && mem_gnt) || (state_q == ST_WAIT) ||
                          (state_q == ST_CHECK) || (state_q == ST_WRITE);
  assign race = in_race_window && cpu_wr_valid && (cpu_wr_addr == addr_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and memory-port control.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    busy    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (en && ivl_q == CNT_LAST) state_d = ST_READ;
      end
      ST_READ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (syn_class == CORR && !abort_q && !race) state_d = ST_WRITE;
        else                                        state_d = ST_NEXT;
      end
      ST_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_gnt || race) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (addr_q == '1 || !en) state_d = ST_IDLE;
        else                     state_d = ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: interval counter, address walk, capture, reporting, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      ivl_q        <= '0;
      rdata_q      <= '0;
      wdata_q      <= '0;
      abort_q      <= 1'b0;
      err_valid_q  <= 1'b0;
      err_uncorr_q <= 1'b0;
      err_addr_q   <= '0;
      corr_q       <= '0;
      uncorr_q     <= '0;
      pass_done_q  <= 1'b0;
    end else begin
      err_valid_q <= 1'b0;
      pass_done_q <= 1'b0;
      if (race) abort_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            if (ivl_q == CNT_LAST) ivl_q <= '0;
            else                   ivl_q <= ivl_q + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          rdata_q <= mem_rdata;
        end
        ST_CHECK: begin
          wdata_q <= corr_cw;
          if (syn_class != CLEAN) begin
            err_valid_q  <= 1'b1;
            err_uncorr_q <= (syn_class == UNCORR);
            err_addr_q   <= addr_q;
            if (syn_class == CORR) begin
              if (corr_q != CNT_SAT) corr_q <= corr_q + 16'd1;
            end else begin
              if (uncorr_q != CNT_SAT) uncorr_q <= uncorr_q + 16'd1;
            end
          end
        end
        ST_NEXT: begin
          addr_q  <= addr_q + ADDR_W'(1);
          abort_q <= 1'b0;
          if (addr_q == '1) pass_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign err_valid  = err_valid_q;
  assign err_uncorr = err_uncorr_q;
  assign err_addr   = err_addr_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
  assign pass_done  = pass_done_q;

endmodule

// File: tb/tb_ecc_mem_scrubber.sv
// Bench for ecc_mem_scrubber: memory/arbiter environment, reference model
// built from the codeword rules, scoreboard of expected reports and writes.
module tb_ecc_mem_scrubber;

  localparam int ADDR_W         = 3;
  localparam int SCRUB_INTERVAL = 4;
  localparam int N_WORDS        = 8;
  localparam int EW             = 2 + 1 + ADDR_W + 39;
  localparam logic [1:0] K_ERR  = 2'd0;
  localparam logic [1:0] K_WR   = 2'd1;
  localparam logic [1:0] K_PASS = 2'd2;

  logic              clk = 1'b0;
  logic              rst, en;
  logic              mem_req, mem_we, mem_gnt;
  logic [ADDR_W-1:0] mem_addr, cpu_wr_addr, err_addr;
  logic [38:0]       mem_wdata, mem_rdata;
  logic              cpu_wr_valid, busy, err_valid, err_uncorr, pass_done;
  logic [15:0]       corr_cnt, uncorr_cnt;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [38:0]   mem [N_WORDS];
  int flip_a [N_WORDS];
  int flip_b [N_WORDS];
  int corr_m, uncorr_m, last_err;
  int gnt_mode;        // 0 always grant, 1 random, 2 withhold writes
  bit race_arm;
  int race_addr;
  int hold_cnt;
  int cyc;
  bit found;

  ecc_mem_scrubber #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(SCRUB_INTERVAL)) dut (
    .clk(clk), .rst(rst), .en(en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr),
    .busy(busy), .err_valid(err_valid), .err_uncorr(err_uncorr), .err_addr(err_addr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .pass_done(pass_done)
  );

  // Clock.
  always #5 clk = ~clk;

  // Hamming encoder from the layout rules: data in non-power-of-two
  // positions, check bit 2^j makes its parity group even, bit 0 overall parity.
  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] cw;
    int k;
    cw = '0;
    k = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p < 39; p++)
        if (((p >> j) & 1) == 1 && p != (1 << j)) par = par ^ cw[p];
      cw[1 << j] = par;
    end
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic int data_pos(input int k);
    int n;
    n = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) return p;
        n++;
      end
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_event(input logic [EW-1:0] act, input string name);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s unexpected actual=%0h required=none", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  task automatic clear_flips();
    for (int w = 0; w < N_WORDS; w++) begin
      flip_a[w] = -1;
      flip_b[w] = -1;
    end
  endtask

  // Fill memory for one pass and queue what a correct scrubber must do.
  task automatic load_pass();
    for (int w = 0; w < N_WORDS; w++) begin
      logic [38:0] good, cw;
      int nf;
      good = encode($urandom());
      cw = good;
      nf = 0;
      if (flip_a[w] >= 0) begin cw[flip_a[w]] = ~cw[flip_a[w]]; nf++; end
      if (flip_b[w] >= 0) begin cw[flip_b[w]] = ~cw[flip_b[w]]; nf++; end
      mem[w] = cw;
      if (nf == 1) begin
        exp_q.push_back({K_ERR, 1'b0, ADDR_W'(w), 39'h0});
        if (!(race_arm && w == race_addr)) exp_q.push_back({K_WR, 1'b0, ADDR_W'(w), good});
        if (corr_m < 65535) corr_m++;
        last_err = w;
      end else if (nf == 2) begin
        exp_q.push_back({K_ERR, 1'b1, ADDR_W'(w), 39'h0});
        if (uncorr_m < 65535) uncorr_m++;
        last_err = w;
      end
    end
    exp_q.push_back({K_PASS, 1'b0, ADDR_W'(0), 39'h0});
  endtask

  task automatic random_flips();
    for (int w = 0; w < N_WORDS; w++) begin
      int r;
      r = $urandom_range(0, 9);
      flip_a[w] = -1;
      flip_b[w] = -1;
      if (r >= 6) flip_a[w] = $urandom_range(0, 38);
      if (r >= 8) begin
        do flip_b[w] = $urandom_range(0, 38); while (flip_b[w] == flip_a[w]);
      end
    end
  endtask

  task automatic wait_pass(input bit rand_en, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (rand_en) en = ($urandom_range(0, 7) != 0);
    end while (!pass_done && n < 3000);
    #2;
    en = 1'b1;
    check("pass_in_time", 64'(n < 3000), 64'(1));
    if (n >= 3000) exp_q.delete();
  endtask

  task automatic check_model(input string tag);
    check({tag, "_corr_cnt"}, 64'(corr_cnt), 64'(corr_m));
    check({tag, "_uncorr_cnt"}, 64'(uncorr_cnt), 64'(uncorr_m));
    check({tag, "_err_addr"}, 64'(err_addr), 64'(last_err));
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Memory and arbiter environment, plus the core-write race injector.
  initial begin
    mem_gnt = 1'b1;
    mem_rdata = '0;
    cpu_wr_valid = 1'b0;
    cpu_wr_addr = '0;
    hold_cnt = 0;
    forever begin
      @(negedge clk);
      cpu_wr_valid = 1'b0;
      case (gnt_mode)
        1: mem_gnt = ($urandom_range(0, 3) != 0);
        2: mem_gnt = !mem_we;
        default: mem_gnt = 1'b1;
      endcase
      if (race_arm && mem_req && mem_we && int'(mem_addr) == race_addr) begin
        mem_gnt = 1'b0;
        hold_cnt++;
        if (hold_cnt == 3) begin
          cpu_wr_valid = 1'b1;
          cpu_wr_addr = mem_addr;
          mem[mem_addr] = encode($urandom());
          race_arm = 1'b0;
          hold_cnt = 0;
        end
      end
      if (mem_req && mem_gnt) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem[mem_addr];
      end
    end
  end

  // Monitor: pops the scoreboard on every report, granted write and pass end;
  // also checks that a pending request does not change.
  initial begin
    logic              prev_hold;
    logic              pw;
    logic [ADDR_W-1:0] pa;
    logic [38:0]       pd;
    prev_hold = 1'b0;
    pw = 1'b0;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (err_valid) expect_event({K_ERR, err_uncorr, err_addr, 39'h0}, "err_report");
      if (mem_req && mem_we && mem_gnt) expect_event({K_WR, 1'b0, mem_addr, mem_wdata}, "scrub_write");
      if (pass_done) expect_event({K_PASS, 1'b0, {ADDR_W{1'b0}}, 39'h0}, "pass_done");
      if (prev_hold && mem_req)
        check("req_hold", 64'({mem_we, mem_addr, mem_wdata}), 64'({pw, pa, pd}));
      prev_hold = mem_req && !mem_gnt;
      pw = mem_we;
      pa = mem_addr;
      pd = mem_wdata;
    end
  end

  // Watchdog.
  initial begin
    #600000;
    bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stimulus.
  initial begin
    rst = 1'b1;
    en = 1'b0;
    gnt_mode = 0;
    race_arm = 1'b0;
    race_addr = 0;
    corr_m = 0;
    uncorr_m = 0;
    last_err = 0;
    clear_flips();
    repeat (3) @(negedge clk);

    check("rst_ctrl", 64'({mem_req, mem_we, busy, err_valid, err_uncorr, pass_done}), 64'(0));
    check("rst_addr_data", 64'({mem_addr, mem_wdata, err_addr}), 64'(0));
    check("rst_counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));

    // Clean memory, immediate grants: 4 idle cycles plus 8 words of 4 cycles.
    load_pass();
    rst = 1'b0;
    en = 1'b1;
    wait_pass(1'b0, cyc);
    check("clean_pass_latency", 64'(cyc), 64'(36));
    check_model("clean");

    // Single data-bit error at word 3, double error at word 6, parity bit at word 1.
    clear_flips();
    flip_a[3] = data_pos(5);
    flip_a[6] = 3;
    flip_b[6] = 9;
    flip_a[1] = 0;
    load_pass();
    wait_pass(1'b0, cyc);
    check_model("directed");

    // Core writes the word while the scrubber's write grant is withheld.
    clear_flips();
    flip_a[2] = 17;
    race_addr = 2;
    race_arm = 1'b1;
    load_pass();
    wait_pass(1'b0, cyc);
    check("race_injected", 64'(race_arm), 64'(0));
    check_model("race");
    race_arm = 1'b0;

    // Randomized passes with random grants and enable drops.
    gnt_mode = 1;
    for (int i = 0; i < 12; i++) begin
      random_flips();
      load_pass();
      wait_pass(1'b1, cyc);
      check_model("random");
    end
    gnt_mode = 0;

    // Saturation: preload both counters near the top.
    force dut.corr_q = 16'hFFFD;
    force dut.uncorr_q = 16'hFFFE;
    @(negedge clk);
    release dut.corr_q;
    release dut.uncorr_q;
    corr_m = 65533;
    uncorr_m = 65534;
    clear_flips();
    flip_a[0] = 4;
    flip_a[2] = 30;
    flip_a[5] = 38;
    flip_a[7] = 0;
    flip_a[3] = 1;
    flip_b[3] = 2;
    flip_a[4] = 11;
    flip_b[4] = 33;
    load_pass();
    wait_pass(1'b0, cyc);
    check_model("saturate");

    // Reset while a corrected write is waiting for its grant.
    gnt_mode = 2;
    clear_flips();
    flip_a[4] = 20;
    load_pass();
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    check("write_reached", 64'(found), 64'(1));
    #3;
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("rst_write_req", 64'(mem_req), 64'(0));
    check("rst_write_ctrl", 64'({mem_we, busy, err_valid, err_uncorr, pass_done}), 64'(0));
    check("rst_write_data", 64'({mem_addr, mem_wdata, err_addr}), 64'(0));
    check("rst_write_counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));
    corr_m = 0;
    uncorr_m = 0;
    last_err = 0;
    gnt_mode = 0;
    clear_flips();
    load_pass();
    rst = 1'b0;
    en = 1'b1;
    wait_pass(1'b0, cyc);
    check("post_rst_latency", 64'(cyc), 64'(36));
    check_model("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
